// File: rtl/enc8b10b_pkg.sv
// Shared constants and code tables for the 8b/10b encoder.
//
// Holds the 5b/6b data table (stored as RD- codes; the RD+ code is the bitwise
// inverse for entries flagged in FLIP_6B), the 3b/4b data and K tables (also
// stored as RD- codes), the K28 and alternate-7 constants, the legal-K check,
// and the byte/code lane widths.
package enc8b10b_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CODE_W = 10;

    localparam logic [4:0] K28_X      = 5'd28;
    localparam logic [2:0] K28_5_Y    = 3'd5;
    localparam logic [5:0] K28_6B_NEG = 6'b001111;
    localparam logic [3:0] A7_4B_NEG  = 4'b0111;

    // A set bit marks a 6b entry that is inverted at RD+ and toggles the
    // sub-block RD: every unbalanced code, plus D.7 (111000/000111).
    localparam logic [31:0] FLIP_6B = 32'hE981_8197;
    // Same for the 4b sub-block: y = 0, 3, 4, 7.
    localparam logic [7:0]  FLIP_4B = 8'h99;

    // 5b/6b data table, abcdei with a in bit 5, RD- column.
    function automatic logic [5:0] d6_neg(input logic [4:0] x);
        logic [5:0] c;
        c = 6'b000000;
        unique case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            5'd31: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b data table, fghj with f in bit 3, RD- column (D.x.P7 for y = 7).
    function automatic logic [3:0] d4_neg(input logic [2:0] y);
        logic [3:0] c;
        c = 4'b0000;
        unique case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            3'd7: c = 4'b1110;
        endcase
        return c;
    endfunction

    // 3b/4b K table, RD- column. K codes invert at RD+ even when balanced.
    function automatic logic [3:0] k4_neg(input logic [2:0] y);
        logic [3:0] c;
        c = 4'b0000;
        unique case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b0110;
            3'd2: c = 4'b1010;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b0101;
            3'd6: c = 4'b1001;
            3'd7: c = 4'b0111;
        endcase
        return c;
    endfunction

    // Data bytes whose P7 code would create a run of five at this sub-block RD.
    function automatic logic a7_needed(input logic [4:0] x, input logic rd);
        logic neg_set;
        logic pos_set;
        neg_set = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        pos_set = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        return rd ? pos_set : neg_set;
    endfunction

    // K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
    function automatic logic is_legal_k(input logic [7:0] b);
        logic k28;
        logic kx7;
        k28 = (b[4:0] == K28_X);
        kx7 = (b[7:5] == 3'd7) &&
              ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
               (b[4:0] == 5'd29) || (b[4:0] == 5'd30));
        return k28 || kx7;
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Single-lane combinational 8b/10b encoder.
//
// Ports:
//   data_byte  in  8   HGF = [7:5], EDCBA = [4:0]
//   k          in  1   byte is a control character
//   rd_in      in  1   running disparity before this byte (1 = RD+)
//   code       out 10  abcdei = [9:4], fghj = [3:0]
//   rd_out     out 1   running disparity after this byte
//   k_illegal  out 1   k set on a byte outside the legal K set
//
// Build option ENC_KCHECK_EN: when defined, an illegal K byte is replaced by
// K28.5 and flagged on k_illegal; otherwise it is encoded through the data
// table with the alternate 7 forced and k_illegal stays 0.
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [BYTE_W-1:0] data_byte,
    input  logic              k,
    input  logic              rd_in,
    output logic [CODE_W-1:0] code,
    output logic              rd_out,
    output logic              k_illegal
);

    logic       legal_k;
    logic       bad_k;
    logic [4:0] x;
    logic [2:0] y;
    logic       use_k;
    logic       force_a7;

    logic [5:0] code6;
    logic [3:0] code4;
    logic       rd6;
    logic       alt7;

    assign legal_k = is_legal_k(data_byte);
    assign bad_k   = k && !legal_k;

`ifdef ENC_KCHECK_EN
    assign x         = bad_k ? K28_X : data_byte[4:0];
    assign y         = bad_k ? K28_5_Y : data_byte[7:5];
    assign use_k     = k;
    assign force_a7  = 1'b0;
    assign k_illegal = bad_k;
`else
    assign x         = data_byte[4:0];
    assign y         = data_byte[7:5];
    assign use_k     = k && legal_k;
    assign force_a7  = bad_k;
    assign k_illegal = 1'b0;
`endif

    always_comb begin
        code6  = d6_neg(x);
        rd6    = rd_in;
        code4  = d4_neg(y);
        rd_out = rd_in;
        alt7   = 1'b0;

        // 5b/6b sub-block
        if (use_k && (x == K28_X)) begin
            code6 = rd_in ? ~K28_6B_NEG : K28_6B_NEG;
            rd6   = ~rd_in;
        end else if (FLIP_6B[x]) begin
            code6 = rd_in ? ~d6_neg(x) : d6_neg(x);
            rd6   = ~rd_in;
        end

        // 3b/4b sub-block, selected by the RD left by the 6b code
        alt7   = (y == 3'd7) && (force_a7 || a7_needed(x, rd6));
        rd_out = rd6;
        if (use_k) begin
            code4 = rd6 ? ~k4_neg(y) : k4_neg(y);
            if (FLIP_4B[y]) begin
                rd_out = ~rd6;
            end
        end else if (alt7) begin
            code4  = rd6 ? ~A7_4B_NEG : A7_4B_NEG;
            rd_out = ~rd6;
        end else if (FLIP_4B[y]) begin
            code4  = rd6 ? ~d4_neg(y) : d4_neg(y);
            rd_out = ~rd6;
        end
    end

    assign code = {code6, code4};

endmodule

// File: rtl/enc8b10b_multilane.sv
// Multi-lane 8b/10b encoder with valid/ready handshake and one output register.
// Running disparity chains lane 0 -> lane NUM_LANES-1 within a word and is
// carried to the next accepted word.
//
// Parameters:
//   NUM_LANES  bytes encoded per cycle (1..8); lane 0 goes first on the wire
//   INIT_RD    running disparity loaded at reset (0 = RD-, 1 = RD+)
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   in_valid/in_ready  input handshake; in_ready = !out_valid || out_ready
//   data_in            lane i at [8i+7:8i]
//   k_in               per-lane control-character flag
//   out_valid/out_ready output handshake
//   code_out           lane i at [10i+9:10i], bit 9 of each lane sent first
//   running_disparity  RD after the last lane of the latest accepted word
//   k_err              per-lane illegal-K flag, registered with the word
//
// Build option ENC_KCHECK_EN enables illegal-K substitution and k_err;
// without it k_err is always 0.
module enc8b10b_multilane
    import enc8b10b_pkg::*;
#(
    parameter int unsigned NUM_LANES = 1,
    parameter bit          INIT_RD   = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BYTE_W*NUM_LANES-1:0] data_in,
    input  logic [NUM_LANES-1:0]        k_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CODE_W*NUM_LANES-1:0] code_out,
    output logic                        running_disparity,
    output logic [NUM_LANES-1:0]        k_err
);

    logic                        out_valid_q;
    logic [CODE_W*NUM_LANES-1:0] code_q;
    logic [NUM_LANES-1:0]        k_err_q;
    logic                        rd_q;

    logic [NUM_LANES:0]          rd_chain;
    logic [CODE_W*NUM_LANES-1:0] code_next;
    logic [NUM_LANES-1:0]        k_illegal_next;
    logic                        accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign rd_chain[0] = rd_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        enc8b10b_lane u_lane (
            .data_byte (data_in[BYTE_W*i +: BYTE_W]),
            .k         (k_in[i]),
            .rd_in     (rd_chain[i]),
            .code      (code_next[CODE_W*i +: CODE_W]),
            .rd_out    (rd_chain[i+1]),
            .k_illegal (k_illegal_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            k_err_q     <= '0;
            rd_q        <= INIT_RD;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            code_q      <= code_next;
            k_err_q     <= k_illegal_next;
            rd_q        <= rd_chain[NUM_LANES];
        end else if (out_ready) begin
            // Word consumed with nothing behind it; code_out keeps its value.
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid         = out_valid_q;
    assign code_out          = code_q;
    assign k_err             = k_err_q;
    assign running_disparity = rd_q;

endmodule

// File: tb/tb_enc8b10b_multilane.sv
module tb_enc8b10b_multilane;

    typedef struct packed {
        logic [19:0] code;
        logic        rd;
        logic [1:0]  kerr;
    } exp_t;

    logic clk;
    logic reset;

    // single-lane instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, rd1, k1;
    logic [7:0]  data1;
    logic [9:0]  code1;
    logic [0:0]  kerr1;

    // two-lane instance
    logic        in_valid2, in_ready2, out_valid2, out_ready2, rd2;
    logic [15:0] data2;
    logic [1:0]  k2, kerr2;
    logic [19:0] code2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    enc8b10b_multilane #(.NUM_LANES(1), .INIT_RD(1'b0)) dut1 (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid1),
        .in_ready          (in_ready1),
        .data_in           (data1),
        .k_in              (k1),
        .out_valid         (out_valid1),
        .out_ready         (out_ready1),
        .code_out          (code1),
        .running_disparity (rd1),
        .k_err             (kerr1)
    );

    enc8b10b_multilane #(.NUM_LANES(2), .INIT_RD(1'b0)) dut2 (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid2),
        .in_ready          (in_ready2),
        .data_in           (data2),
        .k_in              (k2),
        .out_valid         (out_valid2),
        .out_ready         (out_ready2),
        .code_out          (code2),
        .running_disparity (rd2),
        .k_err             (kerr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per transfer (out_valid && out_ready).
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid1 && out_ready1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL lane1_unexpected: got code %b with nothing expected", code1);
            end else begin
                e = q1.pop_front();
                if (code1 !== e.code[9:0] || rd1 !== e.rd || kerr1 !== e.kerr[0:0]) begin
                    n_fail++;
                    $display("FAIL lane1_word: got code %b rd %b kerr %b expected code %b rd %b kerr %b",
                             code1, rd1, kerr1, e.code[9:0], e.rd, e.kerr[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid2 && out_ready2) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL lane2_unexpected: got code %b with nothing expected", code2);
            end else begin
                e = q2.pop_front();
                if (code2 !== e.code || rd2 !== e.rd || kerr2 !== e.kerr) begin
                    n_fail++;
                    $display("FAIL lane2_word: got code %b rd %b kerr %b expected code %b rd %b kerr %b",
                             code2, rd2, kerr2, e.code, e.rd, e.kerr);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send1(input logic [7:0] d, input logic kk, input logic [9:0] ec,
                         input logic erd, input logic ek);
        exp_t e;
        in_valid1 = 1'b1;
        data1     = d;
        k1        = kk;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready1) begin
                e.code = {10'd0, ec};
                e.rd   = erd;
                e.kerr = {1'b0, ek};
                q1.push_back(e);
                @(posedge clk);
                #1;
                in_valid1 = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send1_timeout: in_ready stayed 0 for byte %h", d);
        in_valid1 = 1'b0;
    endtask

    task automatic send2(input logic [15:0] d, input logic [1:0] kk, input logic [19:0] ec,
                         input logic erd, input logic [1:0] ek);
        exp_t e;
        in_valid2 = 1'b1;
        data2     = d;
        k2        = kk;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready2) begin
                e.code = ec;
                e.rd   = erd;
                e.kerr = ek;
                q2.push_back(e);
                @(posedge clk);
                #1;
                in_valid2 = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send2_timeout: in_ready stayed 0 for word %h", d);
        in_valid2 = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20; t++) begin
            if (q1.size() == 0 && q2.size() == 0) return;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: %0d/%0d expected words never appeared", q1.size(), q2.size());
    endtask

    initial begin
        reset     = 1'b1;
        in_valid1 = 1'b0; data1 = '0; k1 = 1'b0; out_ready1 = 1'b1;
        in_valid2 = 1'b0; data2 = '0; k2 = '0;   out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid1", out_valid1, 0);
        check("rst_code1",  code1, 0);
        check("rst_rd1",    rd1, 0);
        check("rst_kerr1",  kerr1, 0);
        check("rst_valid2", out_valid2, 0);
        check("rst_code2",  code2, 0);
        check("rst_rd2",    rd2, 0);
        check("rst_ready1", in_ready1, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two lanes: RD chains lane 0 -> lane 1 and across words.
        send2({8'hB5, 8'hBC}, 2'b01, {10'b1010101010, 10'b0011111010}, 1'b1, 2'b00);
        send2({8'hBC, 8'h00}, 2'b10, {10'b1100000101, 10'b0110001011}, 1'b0, 2'b00);
        send2({8'hE7, 8'hF1}, 2'b00, {10'b0001111110, 10'b1000110111}, 1'b1, 2'b00);
        drain();

        // Single lane, back-to-back.
        send1(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);  // D0.0 RD-
        send1(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
        send1(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);  // K28.5 RD-
        send1(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);  // K28.5 RD+
        send1(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
        send1(8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0);  // D11.7 RD+ -> A7
        send1(8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0);  // D17.7 RD- -> A7
        send1(8'hF1, 1'b0, 10'b1000110001, 1'b0, 1'b0);  // D17.7 RD+ -> P7
        send1(8'hEB, 1'b0, 10'b1101001110, 1'b1, 1'b0);  // D11.7 RD- -> P7
        send1(8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0);  // D21.5 RD+
        send1(8'hE7, 1'b0, 10'b0001111110, 1'b1, 1'b0);  // D7.7 RD+
        send1(8'h63, 1'b0, 10'b1100010011, 1'b0, 1'b0);  // D3.3 RD+
        drain();

        // Backpressure: first word held, second waits at the input.
        out_ready1 = 1'b0;
        send1(8'h5F, 1'b0, 10'b1010110101, 1'b1, 1'b0);  // D31.2 RD-
        in_valid1 = 1'b1;
        data1     = 8'h8F;
        k1        = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready1, 0);
            check("bp_code",     code1, 10'b1010110101);
            check("bp_rd",       rd1, 1);
            @(posedge clk);
            #1;
        end
        out_ready1 = 1'b1;
        send1(8'h8F, 1'b0, 10'b1010001101, 1'b1, 1'b0);  // D15.4 RD+
        send1(8'hFC, 1'b1, 10'b1100000111, 1'b1, 1'b0);  // K28.7 RD+
        send1(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);  // K28.5 RD+
        drain();

        // Illegal K byte at RD-.
`ifdef ENC_KCHECK_EN
        send1(8'h00, 1'b1, 10'b0011111010, 1'b1, 1'b1);
`else
        send1(8'h00, 1'b1, 10'b1001110100, 1'b0, 1'b0);
`endif
        drain();

        // Reset with a word held and another offered: both discarded.
        out_ready1 = 1'b0;
        send1(8'h00, 1'b0, 10'b0, 1'b0, 1'b0);
        reset      = 1'b1;
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        data1      = 8'h00;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid1 = 1'b0;
        q1.delete();
        check("mid_rst_valid", out_valid1, 0);
        check("mid_rst_rd",    rd1, 0);
        check("mid_rst_code",  code1, 0);
        check("mid_rst_kerr",  kerr1, 0);

        send1(8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0);  // K23.7 RD-
        send1(8'h1C, 1'b1, 10'b0011110100, 1'b0, 1'b0);  // K28.0 RD-
        send1(8'h3C, 1'b1, 10'b0011111001, 1'b1, 1'b0);  // K28.1 RD-
        drain();
        @(posedge clk);
        #1;
        check("end_idle1", out_valid1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
